// File: rtl/io_pkg.sv
// Shared IO address map and status-register bit positions, used by the
// IO responder and by DataMemory to route processor accesses.
package io_pkg;

    localparam logic [31:0] IO_ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] IO_ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] IO_ADDR_LEDG  = 32'hF000_0008;
    localparam logic [31:0] IO_ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] IO_ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] IO_ADDR_KCTRL = 32'hF000_0110;
    localparam logic [31:0] IO_ADDR_SCTRL = 32'hF000_0114;

    localparam int STAT_READY   = 0;
    localparam int STAT_OVERRUN = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_HEX,
        SEL_LEDR,
        SEL_LEDG,
        SEL_KEY,
        SEL_SW,
        SEL_KCTRL,
        SEL_SCTRL
    } io_sel_e;

endpackage

// File: rtl/io_input_stage.sv
// One board-input group: 2-flop synchronizer, optional debounce (IO_DEBOUNCE_EN),
// accepted data register and ready/overrun status flags.
module io_input_stage #(
    parameter int          WIDTH           = 4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    input  logic             rd_clear,
    input  logic             ovr_clear,
    output logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             overrun
);

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] stable;
    logic             stable_valid;
    logic             accept;

    // NOTE: synchronizer flops are reset so no stale sample survives a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            // NOTE: non-blocking assignments give the two-stage shift its register semantics.
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    logic [WIDTH-1:0] cand;
    logic [15:0]      cnt;

    // cnt = number of consecutive cycles sync2 has equalled cand; saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= 16'd1;
        end else if (cnt < DEBOUNCE_CYCLES) begin
            cnt  <= cnt + 16'd1;
        end
    end

    assign stable       = cand;
    assign stable_valid = (cnt >= DEBOUNCE_CYCLES);
`else
    localparam logic [15:0] unused_debounce = DEBOUNCE_CYCLES;

    assign stable       = sync2;
    assign stable_valid = 1'b1;
`endif

    assign accept = stable_valid && (stable != data);

    // A read in the acceptance cycle consumes the old value, so it is not an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            data    <= '0;
            ready   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                data  <= stable;
                ready <= 1'b1;
            end else if (rd_clear) begin
                ready <= 1'b0;
            end

            if (accept && ready && !rd_clear) begin
                overrun <= 1'b1;
            end else if (ovr_clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_seg_decoder.sv
// Hex digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module seven_seg_decoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: a default assignment ahead of the case keeps this purely combinational (no latch).
        seg = 7'b1111111;
        unique case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped board IO: HEX/LEDR/LEDG output registers, KEY/SW inputs with
// status registers. Input debounce is enabled by defining IO_DEBOUNCE_EN.
module io_responder
    import io_pkg::*;
#(
    parameter int                DBITS           = 32,
    parameter logic [DBITS-1:0]  ADDR_HEX        = IO_ADDR_HEX,
    parameter logic [DBITS-1:0]  ADDR_LEDR       = IO_ADDR_LEDR,
    parameter logic [DBITS-1:0]  ADDR_LEDG       = IO_ADDR_LEDG,
    parameter logic [DBITS-1:0]  ADDR_KEY        = IO_ADDR_KEY,
    parameter logic [DBITS-1:0]  ADDR_SW         = IO_ADDR_SW,
    parameter logic [DBITS-1:0]  ADDR_KCTRL      = IO_ADDR_KCTRL,
    parameter logic [DBITS-1:0]  ADDR_SCTRL      = IO_ADDR_SCTRL,
    parameter logic [15:0]       DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wrData,
    input  logic             wrEn,
    input  logic             rdEn,
    output logic [DBITS-1:0] rdData,
    output logic             hit,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    io_sel_e     sel;
    logic [15:0] hex_reg;
    logic [3:0]  key_data;
    logic [9:0]  sw_data;
    logic        key_ready, key_overrun, sw_ready, sw_overrun;
    logic        unused_wr_bits;

    assign unused_wr_bits = ^wrData[DBITS-1:16];

    always_comb begin
        sel = SEL_NONE;
        if      (addr == ADDR_HEX)   sel = SEL_HEX;
        else if (addr == ADDR_LEDR)  sel = SEL_LEDR;
        else if (addr == ADDR_LEDG)  sel = SEL_LEDG;
        else if (addr == ADDR_KEY)   sel = SEL_KEY;
        else if (addr == ADDR_SW)    sel = SEL_SW;
        else if (addr == ADDR_KCTRL) sel = SEL_KCTRL;
        else if (addr == ADDR_SCTRL) sel = SEL_SCTRL;
    end

    assign hit = (sel != SEL_NONE);

    always_comb begin
        rdData = '0;
        case (sel)
            SEL_HEX:   rdData[15:0] = hex_reg;
            SEL_LEDR:  rdData[9:0]  = LEDR;
            SEL_LEDG:  rdData[7:0]  = LEDG;
            SEL_KEY:   rdData[3:0]  = key_data;
            SEL_SW:    rdData[9:0]  = sw_data;
            SEL_KCTRL: begin
                rdData[STAT_READY]   = key_ready;
                rdData[STAT_OVERRUN] = key_overrun;
            end
            SEL_SCTRL: begin
                rdData[STAT_READY]   = sw_ready;
                rdData[STAT_OVERRUN] = sw_overrun;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_reg <= '0;
            LEDR    <= '0;
            LEDG    <= '0;
        end else if (wrEn) begin
            case (sel)
                SEL_HEX:  hex_reg <= wrData[15:0];
                SEL_LEDR: LEDR    <= wrData[9:0];
                SEL_LEDG: LEDG    <= wrData[7:0];
                default: ;
            endcase
        end
    end

    // KEY is active-low on the board; the stage works on pressed = 1.
    io_input_stage #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk       (clk),
        .reset     (reset),
        .raw       (~KEY),
        .rd_clear  (rdEn && (sel == SEL_KEY)),
        .ovr_clear (wrEn && (sel == SEL_KCTRL) && !wrData[STAT_OVERRUN]),
        .data      (key_data),
        .ready     (key_ready),
        .overrun   (key_overrun)
    );

    io_input_stage #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk       (clk),
        .reset     (reset),
        .raw       (SW),
        .rd_clear  (rdEn && (sel == SEL_SW)),
        .ovr_clear (wrEn && (sel == SEL_SCTRL) && !wrData[STAT_OVERRUN]),
        .data      (sw_data),
        .ready     (sw_ready),
        .overrun   (sw_overrun)
    );

    seven_seg_decoder u_hex0 (.digit(hex_reg[3:0]),   .seg(HEX0));
    seven_seg_decoder u_hex1 (.digit(hex_reg[7:4]),   .seg(HEX1));
    seven_seg_decoder u_hex2 (.digit(hex_reg[11:8]),  .seg(HEX2));
    seven_seg_decoder u_hex3 (.digit(hex_reg[15:12]), .seg(HEX3));

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter DBITS, default 32, meaning data/address width.
REQ-002 SHALL have parameters ADDR_HEX/ADDR_LEDR/ADDR_LEDG/ADDR_KEY/ADDR_SW, defaults 32'hF0000000/04/08/10/14, meaning data register addresses.
REQ-003 SHALL have parameters ADDR_KCTRL/ADDR_SCTRL, defaults 32'hF0000110/32'hF0000114, meaning KEY/SW status register addresses.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, meaning stable cycles before input acceptance.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have ports addr (in, DBITS), wrData (in, DBITS), wrEn (in, 1), rdEn (in, 1), meaning the processor bus request.
REQ-008 SHALL have ports rdData (out, DBITS) and hit (out, 1), meaning read data and address-decoded-to-IO.
REQ-009 SHALL have ports KEY (in, 4, active-low) and SW (in, 10), meaning board inputs.
REQ-010 SHALL have ports LEDR (out, 10), LEDG (out, 8), HEX0..HEX3 (out, 7 each, active-low segments).

Function
REQ-011 hit SHALL be 1 combinationally iff addr equals one of the seven IO addresses.
REQ-012 rdData SHALL be combinational: KEY -> {28'b0, keyData}; SW -> {22'b0, swData}; KCTRL/SCTRL -> {29'b0, overrun, 1'b0, ready}; HEX -> {16'b0, hexReg}; LEDR/LEDG -> zero-extended register; non-hit -> 0.
REQ-013 wrEn to HEX/LEDR/LEDG SHALL load wrData[15:0]/[9:0]/[7:0] at the next edge; outputs visible the same edge (1-cycle latency).
REQ-014 wrEn to KEY, SW, or any non-hit address SHALL have no effect.
REQ-015 keyData SHALL hold ~KEY as accepted by the input stage; swData SHALL hold SW as accepted.
REQ-016 Acceptance of a value differing from current keyData/swData SHALL update the data register and set ready.
REQ-017 Acceptance while ready already 1 SHALL additionally set overrun.
REQ-018 rdEn with addr==ADDR_KEY (resp. ADDR_SW) SHALL clear ready at the edge.
REQ-019 Same-cycle acceptance and data read SHALL leave ready=1, overrun unchanged (new data wins).
REQ-020 wrEn to KCTRL/SCTRL with wrData[2]==0 SHALL clear overrun; wrData[0] SHALL be ignored.
REQ-021 Same-cycle overrun-set and overrun-clear-write SHALL leave overrun=1.
REQ-022 HEXn SHALL display hex digit hexReg[4n+3:4n], 0-F, active-low standard 7-segment encoding.
REQ-023 Inputs SHALL pass a 2-flop synchronizer before any acceptance logic.

Reset
REQ-024 reset SHALL clear hexReg, LEDR, LEDG, keyData, swData, ready, overrun, debounce counters; HEX0..3 then show "0" (7'b1000000).
REQ-025 reset mid-debounce SHALL discard the pending sample; first acceptance after reset follows full rules.
REQ-026 reset asserted with wrEn SHALL win (registers stay cleared).

Configuration
REQ-027 With IO_DEBOUNCE_EN defined, each input group (KEY, SW) SHALL accept a synchronized value only after DEBOUNCE_CYCLES consecutive identical cycles; any change restarts the counter; counter saturates, never wraps.
REQ-028 Without IO_DEBOUNCE_EN, the synchronized value SHALL be accepted every cycle (change latency 3 edges: 2 sync + 1 register).

Structure
REQ-029 Address constants and status bit indices SHALL live in shared package io_pkg, reused by DataMemory.
REQ-030 The hex-to-7-segment conversion SHALL be sub-module seven_seg_decoder, instantiated four times.
REQ-031 The debounce counter SHALL be one parameterized instance per input group, not per bit.

Verification
REQ-032 Write 32'h0000BEEF to 32'hF0000000 -> next edge HEX3..0 = B,E,E,F; read returns 32'h0000BEEF.
REQ-033 No debounce: SW 0->10'h155 -> after 3 edges swData=10'h155, SCTRL read=1; read SW -> next edge SCTRL=0.
REQ-034 KEY changes twice without read -> KCTRL=32'h5; write 0 to KCTRL -> 32'h1.
REQ-035 KEY change accepted same cycle as KEY read -> KCTRL=1, overrun 0.
REQ-036 IO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: SW glitch 3 cycles -> no update; held 4+ -> update, ready=1.
REQ-037 reset during LED write and pending debounce -> all outputs reset values, HEX "0000", no ready.
